axis_width_downsizer: RTL and testbench

Parametrised AXI4-Stream width downconverter. It splits each wide input beat (RATIO × OUT_BYTES bytes) into up to RATIO narrow output beats, lowest byte lane first. Sub-beats whose keep is all zero are skipped, and tlast is placed on the final emitted sub-beat. It sits between the partitioned hash join output and the host send stream, and generalises the fixed 1024→512 converter to any integer ratio.

---
 rtl/axis_width_downsizer_pkg.sv | 12 +
 rtl/axis_width_downsizer_lowest_set_above.sv | 25 ++
 rtl/axis_width_downsizer.sv | 99 +++++++++
 tb/tb_axis_width_downsizer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_width_downsizer_pkg.sv
// Shared constants and helpers for the AXI4-Stream width downsizer.
package axis_pkg;

  localparam int DEF_OUT_BYTES = 64;
  localparam int DEF_RATIO     = 2;

  // Sub-beat index width; never zero so a ratio of 1 still gets a legal vector.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/axis_width_downsizer_lowest_set_above.sv
// Finds the lowest set bit of a mask strictly above idx (or from bit 0 when from_start).
module lowest_set_above #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] idx,
  input  logic          from_start,
  output logic [IW-1:0] pos,
  output logic          none
);

  // Scan downward so the lowest qualifying position is the last one written.
  always_comb begin
    pos  = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(idx)))) begin
        pos  = i[IW-1:0];
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axis_width_downsizer.sv
// AXI4-Stream width downconverter: splits each wide beat into live narrow sub-beats,
// lowest lane first, with tlast moved onto the final emitted sub-beat.
module axis_width_downsizer
  import axis_pkg::*;
#(
  parameter int OUT_BYTES  = DEF_OUT_BYTES,
  parameter int RATIO      = DEF_RATIO,
  parameter int SKIP_EMPTY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [8*OUT_BYTES*RATIO-1:0]  in_data,
  input  logic [OUT_BYTES*RATIO-1:0]    in_keep,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [8*OUT_BYTES-1:0]        out_data,
  output logic [OUT_BYTES-1:0]          out_keep,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready
);

  localparam int IW = idx_width(RATIO);
  localparam int OW = 8 * OUT_BYTES;

  logic                         occ;
  logic [IW-1:0]                idx;
  logic [OW*RATIO-1:0]          reg_data;
  logic [OUT_BYTES*RATIO-1:0]   reg_keep;
  logic                         reg_last;

  logic [OW-1:0]        sub_data [RATIO];
  logic [OUT_BYTES-1:0] sub_keep [RATIO];
  logic [RATIO-1:0]     live;
  logic [RATIO-1:0]     in_live;

  for (genvar k = 0; k < RATIO; k++) begin : g_slice
    assign sub_data[k] = reg_data[k*OW +: OW];
    assign sub_keep[k] = reg_keep[k*OUT_BYTES +: OUT_BYTES];
    assign live[k]     = (SKIP_EMPTY == 0) || (|reg_keep[k*OUT_BYTES +: OUT_BYTES]);
    assign in_live[k]  = (SKIP_EMPTY == 0) || (|in_keep[k*OUT_BYTES +: OUT_BYTES]);
  end

  logic [IW-1:0] next_pos;
  logic          is_final;
  logic [IW-1:0] first_pos;
  logic          in_none;

  lowest_set_above #(.N(RATIO), .IW(IW)) u_advance (
    .mask       (live),
    .idx        (idx),
    .from_start (1'b0),
    .pos        (next_pos),
    .none       (is_final)
  );

  lowest_set_above #(.N(RATIO), .IW(IW)) u_first (
    .mask       (in_live),
    .idx        ('0),
    .from_start (1'b1),
    .pos        (first_pos),
    .none       (in_none)
  );

  logic any_live;
  logic dropped;

  assign any_live = |live;
  // An all-empty last beat still emits sub-beat 0 (keep 0) to carry the packet boundary.
  assign out_valid = occ && (live[idx] || (!any_live && reg_last));
  assign dropped   = occ && !any_live && !reg_last;
  assign out_data  = sub_data[idx];
  assign out_keep  = sub_keep[idx];
  assign out_last  = reg_last && is_final;
  assign in_ready  = !occ || (out_ready && out_valid && is_final) || dropped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 1'b0;
      idx      <= '0;
      reg_data <= '0;
      reg_keep <= '0;
      reg_last <= 1'b0;
    end else if (in_valid && in_ready) begin
      occ      <= 1'b1;
      idx      <= in_none ? '0 : first_pos;
      reg_data <= in_data;
      reg_keep <= in_keep;
      reg_last <= in_last;
    end else if (out_valid && out_ready) begin
      if (is_final) occ <= 1'b0;
      else          idx <= next_pos;
    end else if (dropped) begin
      occ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Scoreboard bench for axis_width_downsizer at OUT_BYTES=64, RATIO=4.
module tb_axis_width_downsizer;

  localparam int OB = 64;
  localparam int R  = 4;
  localparam int OW = 8 * OB;
  localparam int DW = OW * R;
  localparam int KW = OB * R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [KW-1:0] in_keep;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic [OB-1:0] out_keep;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;

  axis_width_downsizer #(.OUT_BYTES(OB), .RATIO(R), .SKIP_EMPTY(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic [OB-1:0] k;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   last_out_cyc = 0;
  int   ready_mode = 1;  // 0 hold low, 1 hold high, 2 random

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: expected narrow beats for one accepted wide beat.
  task automatic push_exp(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int   lastk;
    exp_t e;
    lastk = -1;
    for (int s = 0; s < R; s++) if (|k[s*OB +: OB]) lastk = s;
    if (lastk < 0) begin
      if (l) begin
        e.d = d[OW-1:0];
        e.k = '0;
        e.l = 1'b1;
        sb.push_back(e);
      end
    end else begin
      for (int s = 0; s <= lastk; s++) begin
        if (|k[s*OB +: OB]) begin
          e.d = d[s*OW +: OW];
          e.k = k[s*OB +: OB];
          e.l = l && (s == lastk);
          sb.push_back(e);
        end
      end
    end
  endtask

  logic          prev_stall = 1'b0;
  logic [OW-1:0] pd;
  logic [OB-1:0] pk;
  logic          pl;

  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", OW'(out_valid), OW'(1));
        chk("hold_data", out_data, pd);
        chk("hold_keep", OW'(out_keep), OW'(pk));
        chk("hold_last", OW'(out_last), OW'(pl));
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_out_cyc = cyc;
        if (sb.size() == 0) begin
          chk("extra_beat_sb_depth", OW'(sb.size()), OW'(1));
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_keep", OW'(out_keep), OW'(e.k));
          chk("out_last", OW'(out_last), OW'(e.l));
        end
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pk = out_keep;
      pl = out_last;
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [KW-1:0] rand_keep();
    logic [KW-1:0] k;
    for (int s = 0; s < R; s++) begin
      case ($urandom_range(0, 3))
        0, 3:    k[s*OB +: OB] = '1;
        1:       k[s*OB +: OB] = '0;
        default: k[s*OB +: OB] = {$urandom, $urandom};
      endcase
    end
    return k;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                      output int acc);
    bit done;
    done     = 1'b0;
    acc      = -1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc  = cyc;
        push_exp(d, k, l);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", OW'(0), OW'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 400 && !idle; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) idle = 1'b1;
    end
    if (!idle) chk("drain_timeout_sb_depth", OW'(sb.size()), OW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int            a0, a1, a2, n0;
    logic [KW-1:0] k_full, k_sub0, k_sparse;
    k_full   = '1;
    k_sub0   = '0;
    k_sub0[0 +: OB] = '1;
    k_sparse = '0;
    k_sparse[1*OB +: OB] = '1;
    k_sparse[3*OB +: OB] = '1;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_keep", OW'(out_keep), OW'(0));
    chk("rst_out_last", OW'(out_last), OW'(0));
    chk("rst_in_ready", OW'(in_ready), OW'(1));
    @(posedge clk);
    #1;

    // Full keep: three beats, 12 sub-beats back to back.
    n0 = n_out;
    send(rand_data(), k_full, 1'b0, a0);
    send(rand_data(), k_full, 1'b0, a1);
    send(rand_data(), k_full, 1'b1, a2);
    drain();
    chk("full_count", OW'(n_out - n0), OW'(3 * R));
    chk("full_accept_spacing", OW'(a2 - a0), OW'(2 * R));
    chk("full_no_gap", OW'(last_out_cyc - a0), OW'(3 * R));

    // Partial tail: one live sub-beat, next beat accepted in its output cycle.
    n0 = n_out;
    send(rand_data(), k_sub0, 1'b1, a0);
    send(rand_data(), k_full, 1'b1, a1);
    drain();
    chk("tail_b2b", OW'(a1 - a0), OW'(1));
    chk("tail_count", OW'(n_out - n0), OW'(1 + R));

    // Sparse keep: sub-beats 1 and 3 only.
    n0 = n_out;
    send(rand_data(), k_sparse, 1'b1, a0);
    send(rand_data(), k_sparse, 1'b0, a1);
    drain();
    chk("sparse_count", OW'(n_out - n0), OW'(4));
    chk("sparse_spacing", OW'(a1 - a0), OW'(2));

    // Empty beats: non-last dropped, last emits keep 0 / last 1.
    n0 = n_out;
    send(rand_data(), '0, 1'b0, a0);
    send(rand_data(), k_sub0, 1'b0, a1);
    send(rand_data(), '0, 1'b1, a2);
    drain();
    chk("empty_drop_spacing", OW'(a1 - a0), OW'(1));
    chk("empty_next_spacing", OW'(a2 - a1), OW'(1));
    chk("empty_count", OW'(n_out - n0), OW'(2));

    // Random backpressure and random keep patterns.
    ready_mode = 2;
    for (int b = 0; b < 40; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(rand_data(), rand_keep(), 1'($urandom_range(0, 1)), a0);
    end
    drain();
    ready_mode = 1;

    // Reset while sub-beat 1 of 4 is pending.
    ready_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    send(rand_data(), k_full, 1'b1, a0);
    ready_mode = 1;
    @(posedge clk);
    #1 ready_mode = 0;
    @(negedge clk);
    chk("pre_rst_pending", OW'(out_valid), OW'(1));
    chk("pre_rst_sb_depth", OW'(sb.size()), OW'(R - 1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", OW'(out_valid), OW'(0));
    chk("rst_mid_in_ready", OW'(in_ready), OW'(1));
    sb.delete();
    #4 rst_n = 1'b1;
    ready_mode = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_stale", OW'(out_valid), OW'(0));
      chk("post_rst_keep", OW'(out_keep), OW'(0));
      chk("post_rst_in_ready", OW'(in_ready), OW'(1));
    end
    @(posedge clk);
    #1;
    n0 = n_out;
    send(rand_data(), k_sparse, 1'b1, a0);
    drain();
    chk("post_rst_count", OW'(n_out - n0), OW'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
